seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 alu_ctr  input  4  operation code.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  WIDTH  primary result: low product, quotient or logic/add result.
REQ-012 result_hi  output  WIDTH  high product word or remainder; zero for other operations.
REQ-013 zero  output  1  result == 0.
REQ-014 div_zero  output  1  DIV or REM was issued with b == 0.

Function
REQ-015 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 MUL, 0100 DIV, 0101 XOR, 0111 SLT (signed a<b -> 1 else 0); all others yield result 0 and take the single-cycle path.
REQ-016 A request is accepted in the cycle where in_valid && in_ready; operands and op are captured, and later input changes have no effect.
REQ-017 States: IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-018 Single-cycle ops: IDLE -> DONE on accept; out_valid is asserted the cycle after accept (latency 1).
REQ-019 MUL: unsigned shift-add, one bit per cycle; IDLE -> BUSY, WIDTH iterations, then DONE; out_valid at accept+WIDTH+1; {result_hi,result} = full 2*WIDTH product.
REQ-020 DIV: unsigned restoring division, one bit per cycle; same timing as MUL; result = quotient, result_hi = remainder.
REQ-021 DIV with b == 0: skip BUSY and go IDLE -> DONE with latency 1; result = all ones, result_hi = a, div_zero = 1.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
REQ-023 DONE holds result, result_hi, zero and div_zero stable while out_valid && !out_ready.
REQ-024 DONE -> IDLE on out_ready; in_ready rises the following cycle, so there is no accept in the same cycle as the hand-off.
REQ-025 out_valid = (state == DONE); outputs are registered, with no combinational path from a, b or alu_ctr.
REQ-026 The counter loads WIDTH-1 on entering BUSY and decrements each cycle; BUSY -> DONE when the counter is 0.
REQ-027 In IDLE, in_valid is ignored only when in_ready is low; it is never dropped while in_ready is high.

Reset
REQ-028 rst_n low forces state=IDLE, counter=0, out_valid=0, result=0, result_hi=0, zero=0, div_zero=0 immediately, regardless of clk.
REQ-029 Reset during BUSY or DONE discards the operation; no result is delivered.
REQ-030 in_ready = 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 Op codes and state encodings are defined in shared package alu_pkg, and no other file redefines them.
REQ-032 The iterative multiply/divide datapath (partial remainder/product register, counter) is sub-module seq_alu_muldiv with start/done handshake; the top holds the FSM and the single-cycle ops.
REQ-033 There is one always block for the asynchronous reset sequential logic per module, and no latches.

Verification
REQ-034 WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1.
REQ-035 MUL a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid at accept+33, result=0x00000001, result_hi=0xFFFFFFFE.
REQ-036 DIV a=100 b=7 -> result=14, result_hi=2, div_zero=0 at accept+33; DIV a=5 b=0 -> result=0xFFFFFFFF, result_hi=5, div_zero=1 at accept+1.
REQ-037 Back-pressure: out_ready=0 for 5 cycles after SLT a=-3 b=2 -> result=1 held stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready pulses.
REQ-038 rst_n pulsed low at iteration 10 of MUL -> out_valid never asserts for that request; a new ADD 2+3 afterwards returns 5 at latency 1.
REQ-039 WIDTH=8 regression: MUL 0xFF*0xFF -> {result_hi,result}=0xFE01 at accept+9; random ops vs reference model, 10k requests with random out_ready.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encodings shared by the sequential ALU
package alu_pkg;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_DIV = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module seq_alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);
  logic             busy, is_div;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opd, p_hi, p_lo;
  logic [WIDTH:0]   sum, trial;
  // p_hi holds the product high word / partial remainder, p_lo the multiplier / dividend-quotient
  assign sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opd} : '0);
  assign trial  = {p_hi, p_lo[WIDTH-1]} - {1'b0, opd};
  assign hi_nxt = is_div ? (trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : trial[WIDTH-1:0])
                         : sum[WIDTH:1];
  assign lo_nxt = is_div ? {p_lo[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], p_lo[WIDTH-1:1]};
  // done marks the final iteration; the top latches lo_nxt/hi_nxt on that edge
  assign done   = busy && cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      opd    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_div <= div;
      cnt    <= CNT_W'(WIDTH - 1);
      opd    <= div ? b : a;
      p_hi   <= '0;
      p_lo   <= div ? a : b;
    end else if (busy) begin
      busy   <= !done;
      cnt    <= done ? '0 : cnt - CNT_W'(1);
      p_hi   <= hi_nxt;
      p_lo   <= lo_nxt;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready sequential ALU with single-cycle logic/arith ops and iterative MUL/DIV
module seq_alu import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_zero
);
  state_e           state;
  logic             accept, iter, start, dz, md_done;
  logic [WIDTH-1:0] alu_res, md_lo, md_hi;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign accept    = in_valid && in_ready;
  assign dz        = alu_ctr == OP_DIV && b == '0;
  assign iter      = alu_ctr == OP_MUL || (alu_ctr == OP_DIV && !dz);
  assign start     = accept && iter;
  // OP_DIV only reaches this path with a zero divisor, which saturates the quotient
  always_comb begin
    alu_res = '0;
    case (alu_ctr)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_DIV:  alu_res = '1;
      default: alu_res = '0;
    endcase
  end
  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .div    (alu_ctr == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .lo_nxt (md_lo),
    .hi_nxt (md_hi)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state <= iter ? S_BUSY : S_DONE;
          if (!iter) begin
            result    <= alu_res;
            result_hi <= dz ? a : '0;
            zero      <= alu_res == '0;
            div_zero  <= dz;
          end
        end
        S_BUSY: if (md_done) begin
          state     <= S_DONE;
          result    <= md_lo;
          result_hi <= md_hi;
          zero      <= md_lo == '0;
          div_zero  <= 1'b0;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (directed WIDTH=32, randomized WIDTH=8)
module tb_seq_alu;
  import alu_pkg::*;
  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        z;
    logic        dz;
    int          lat;
    int          t;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        v32 = 1'b0, rdy32, ov32, or32 = 1'b0, z32, dz32;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0, res32, hi32;
  logic        v8 = 1'b0, rdy8, ov8, or8 = 1'b0, z8, dz8;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, res8, hi8;
  int          checks = 0, passed = 0, cyc = 0;
  exp_t        q32[$], q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .alu_ctr(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(res32),
    .result_hi(hi32), .zero(z32), .div_zero(dz32)
  );
  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .alu_ctr(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(res8),
    .result_hi(hi8), .zero(z8), .div_zero(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else passed++;
  endtask

  function automatic exp_t ref_op(input logic [3:0] op, input logic [63:0] x,
                                  input logic [63:0] y, input int w);
    logic [63:0]  m;
    logic [127:0] p;
    exp_t         e;
    m = (64'd1 << w) - 64'd1;
    e.lo = '0; e.hi = '0; e.dz = 1'b0; e.lat = 1; e.t = 0;
    case (op)
      4'b0000: e.lo = x & y;
      4'b0001: e.lo = x | y;
      4'b0010: e.lo = (x + y) & m;
      4'b0110: e.lo = (x - y) & m;
      4'b0101: e.lo = x ^ y;
      4'b0111: e.lo = {63'd0, $signed(x << (64 - w)) < $signed(y << (64 - w))};
      4'b0011: begin
        p = {64'd0, x} * {64'd0, y};
        e.lo = p[63:0] & m;
        p = p >> w;
        e.hi = p[63:0] & m;
        e.lat = w + 1;
      end
      4'b0100: if (y == 0) begin
        e.lo = m; e.hi = x; e.dz = 1'b1;
      end else begin
        e.lo = x / y; e.hi = x % y; e.lat = w + 1;
      end
      default: e.lo = '0;
    endcase
    e.z = e.lo == 0;
    return e;
  endfunction

  task automatic run32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    op32 = op; a32 = x; b32 = y; v32 = 1'b1;
    chk("in_ready", rdy32, 1);
    q32.push_back(ref_op(op, {32'd0, x}, {32'd0, y}, 32));
    @(posedge clk);
    #1 v32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov32 && lat < 100);
    if (!ov32) begin
      chk("timeout32", 0, 1);
      void'(q32.pop_front());
      return;
    end
    e = q32.pop_front();
    chk("lat32", lat, e.lat);
    chk("result32", res32, e.lo);
    chk("result_hi32", hi32, e.hi);
    chk("zero32", z32, e.z);
    chk("div_zero32", dz32, e.dz);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_result", res32, e.lo);
      chk("hold_valid", ov32, 1);
      chk("hold_in_ready", rdy32, 0);
    end
    or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
    @(negedge clk);
    chk("ready_after_handoff", rdy32, 1);
    chk("valid_after_handoff", ov32, 0);
  endtask

  task automatic drive8();
    exp_t e;
    int   w;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      op8 = (i == 0) ? 4'b0011 : 4'($urandom);
      a8  = (i == 0) ? 8'hFF : 8'($urandom);
      b8  = (i == 0) ? 8'hFF : ($urandom_range(7) == 0 ? 8'd0 : 8'($urandom));
      v8  = 1'b1;
      w = 0;
      while (!rdy8 && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (!rdy8) begin
        chk("drv8_timeout", 0, 1);
        break;
      end
      e = ref_op(op8, {56'd0, a8}, {56'd0, b8}, 8);
      e.t = cyc;
      q8.push_back(e);
      @(posedge clk);
      #1 v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
    end
  endtask

  task automatic monitor8();
    exp_t cur;
    int   got, guard;
    bit   seen;
    got = 0; guard = 0; seen = 1'b0;
    cur = ref_op(4'b0000, '0, '0, 8);
    while (got < 10000 && guard < 80000) begin
      @(negedge clk);
      guard++;
      if (ov8) begin
        if (!seen) begin
          if (q8.size() == 0) chk("spurious8", 1, 0);
          else begin
            cur = q8.pop_front();
            chk("lat8", cyc - cur.t, cur.lat);
          end
          seen = 1'b1;
        end
        chk("result8", res8, cur.lo);
        chk("result_hi8", hi8, cur.hi);
        chk("zero8", z8, cur.z);
        chk("div_zero8", dz8, cur.dz);
        or8 = $urandom_range(3) != 0;
        if (or8) begin
          seen = 1'b0;
          got++;
        end
      end else or8 = 1'($urandom_range(1));
    end
    chk("rx_count8", got, 10000);
  endtask

  initial begin
    int bad;
    #1;
    chk("rst_result", res32, 0);
    chk("rst_result_hi", hi32, 0);
    chk("rst_zero", z32, 0);
    chk("rst_div_zero", dz32, 0);
    chk("rst_valid", ov32, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", rdy32, 1);
    run32(OP_ADD, 32'hFFFFFFFF, 32'd1, 0);
    run32(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run32(OP_DIV, 32'd100, 32'd7, 0);
    run32(OP_DIV, 32'd5, 32'd0, 0);
    run32(OP_SUB, 32'd0, 32'd1, 0);
    run32(OP_XOR, 32'hA5A5F00F, 32'h0FF0A5A5, 1);
    run32(OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 0);
    run32(OP_OR, 32'h12340000, 32'h00005678, 0);
    run32(4'hF, 32'h1234, 32'h5678, 0);
    run32(OP_MUL, 32'd0, 32'hDEADBEEF, 0);
    run32(OP_DIV, 32'd7, 32'd100, 0);
    run32(OP_SLT, 32'd5, 32'hFFFFFFFE, 0);
    run32(OP_SLT, 32'hFFFFFFFD, 32'd2, 5);
    // reset mid-multiply must discard the request
    @(negedge clk);
    op32 = OP_MUL; a32 = 32'h12345; b32 = 32'h6789; v32 = 1'b1;
    @(posedge clk);
    #1 v32 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", res32, 0);
    chk("midrst_valid", ov32, 0);
    chk("midrst_in_ready", rdy32, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) bad++;
    end
    chk("no_valid_after_rst", bad, 0);
    run32(OP_ADD, 32'd2, 32'd3, 0);
    fork
      drive8();
      monitor8();
    join
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
